y86_seq_controller: RTL and testbench

- Multi-cycle stage sequencer for the Y86 SEQ datapath.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPDATE, skipping stages the icode does not need.
- Drives per-stage enables and the decode stage's instr_valid, handshakes with instruction and data memory, and tracks processor status (AOK/HLT/ADR/INS) plus performance counters.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/y86_icode_class.sv | 27 ++
 rtl/y86_seq_controller.sv | 185 ++++++++++++++++++
 tb/tb_y86_seq_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared encodings for the Y86 SEQ stage sequencer: icodes, status codes, FSM states.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVL = 4'd2;
  localparam logic [3:0] I_IRMOVL = 4'd3;
  localparam logic [3:0] I_RMMOVL = 4'd4;
  localparam logic [3:0] I_MRMOVL = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPDATE,
    S_HALT,
    S_ERROR
  } state_e;

endpackage

// File: rtl/y86_icode_class.sv
// Combinational icode classifier: which stages an instruction visits and whether it is defined.
// Zero latency, no flow control.
module y86_icode_class
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       needs_mem,
  output logic       needs_wb,
  output logic       legal
);

  always_comb begin
    needs_mem = 1'b0;
    needs_wb  = 1'b0;
    legal     = (icode <= I_POPQ);
    case (icode)
      I_RMMOVL: needs_mem = 1'b1;
      I_MRMOVL, I_CALL, I_RET, I_PUSHQ, I_POPQ: begin
        needs_mem = 1'b1;
        needs_wb  = 1'b1;
      end
      I_RRMOVL, I_IRMOVL, I_OPQ: needs_wb = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/y86_seq_controller.sv
// Multi-cycle SEQ stage sequencer: F,D,E,[M],[W],P per instruction (4-6 cycles at zero wait).
// Fetch/memory requests are held until acked; the memory wait is bounded by MEM_TIMEOUT.
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic             fetch_req,
  input  logic             fetch_ack,
  input  logic             fetch_err,
  input  logic             instr_ok,
  input  logic [3:0]       icode,
  output logic [3:0]       icode_q,
  output logic             instr_valid,
  output logic             decode_en,
  output logic             execute_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic             mem_err,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [31:0]      TMO_LAST = 32'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       stat_q, stat_d;
  logic [3:0]       icode_d;
  logic [31:0]      tmo_q, tmo_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic             fetch_req_q, fetch_req_d;
  logic             decode_en_q, decode_en_d;
  logic             execute_en_q, execute_en_d;
  logic             mem_req_q, mem_req_d;
  logic             wb_en_q, wb_en_d;
  logic             pc_en_q, pc_en_d;
  logic             busy_q, busy_d;
  logic             retire;

  // Classify the incoming icode while fetching, the latched one afterwards.
  logic [3:0] class_icode;
  logic       cls_needs_mem, cls_needs_wb, cls_legal;

  assign class_icode = (state_q == S_FETCH) ? icode : icode_q;

  y86_icode_class u_class (
    .icode     (class_icode),
    .needs_mem (cls_needs_mem),
    .needs_wb  (cls_needs_wb),
    .legal     (cls_legal)
  );

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    tmo_d   = tmo_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (fetch_ack) begin
          if (fetch_err) begin
            state_d = S_ERROR;
            stat_d  = STAT_ADR;
          end else if (!instr_ok || !cls_legal) begin
            state_d = S_ERROR;
            stat_d  = STAT_INS;
          end else if (icode == I_HALT) begin
            state_d = S_HALT;
            stat_d  = STAT_HLT;
            retire  = 1'b1;
          end else begin
            icode_d = icode;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (cls_needs_mem)     state_d = S_MEMORY;
        else if (cls_needs_wb) state_d = S_WRITEBACK;
        else                   state_d = S_PCUPDATE;
      end
      S_MEMORY: begin
        // An ack arriving on the last allowed cycle beats the timeout.
        if (mem_ack) begin
          tmo_d = '0;
          if (mem_err) begin
            state_d = S_ERROR;
            stat_d  = STAT_ADR;
          end else begin
            state_d = cls_needs_wb ? S_WRITEBACK : S_PCUPDATE;
          end
        end else if ((MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          tmo_d   = '0;
          state_d = S_ERROR;
          stat_d  = STAT_ADR;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_WRITEBACK: state_d = S_PCUPDATE;
      S_PCUPDATE: begin
        retire  = 1'b1;
        state_d = stop ? S_IDLE : S_FETCH;
      end
      S_HALT, S_ERROR: begin
        if (clear) begin
          state_d = S_IDLE;
          stat_d  = STAT_AOK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    fetch_req_d  = (state_d == S_FETCH);
    decode_en_d  = (state_d == S_DECODE);
    execute_en_d = (state_d == S_EXECUTE);
    mem_req_d    = (state_d == S_MEMORY);
    wb_en_d      = (state_d == S_WRITEBACK);
    pc_en_d      = (state_d == S_PCUPDATE);
    busy_d       = !((state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_ERROR));

    cycle_cnt_d   = (busy_q && (cycle_cnt_q != '1)) ? cycle_cnt_q + CNT_ONE : cycle_cnt_q;
    retired_cnt_d = (retire && (retired_cnt_q != '1)) ? retired_cnt_q + CNT_ONE : retired_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      stat_q        <= STAT_AOK;
      icode_q       <= 4'd0;
      tmo_q         <= '0;
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
      fetch_req_q   <= 1'b0;
      decode_en_q   <= 1'b0;
      execute_en_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      wb_en_q       <= 1'b0;
      pc_en_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stat_q        <= stat_d;
      icode_q       <= icode_d;
      tmo_q         <= tmo_d;
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
      fetch_req_q   <= fetch_req_d;
      decode_en_q   <= decode_en_d;
      execute_en_q  <= execute_en_d;
      mem_req_q     <= mem_req_d;
      wb_en_q       <= wb_en_d;
      pc_en_q       <= pc_en_d;
      busy_q        <= busy_d;
    end
  end

  assign fetch_req   = fetch_req_q;
  assign instr_valid = decode_en_q;
  assign decode_en   = decode_en_q;
  assign execute_en  = execute_en_q;
  assign mem_req     = mem_req_q;
  assign wb_en       = wb_en_q;
  assign pc_en       = pc_en_q;
  assign stat        = stat_q;
  assign busy        = busy_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_y86_seq_controller.sv
// Scoreboarded bench for y86_seq_controller: stimulus queues the expected per-cycle stage vector,
// a negedge monitor pops and compares it on every busy cycle.
module tb_y86_seq_controller;

  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  // {fetch_req, decode_en, instr_valid, execute_en, mem_req, wb_en, pc_en}
  localparam logic [6:0] EN_F = 7'b1000000;
  localparam logic [6:0] EN_D = 7'b0110000;
  localparam logic [6:0] EN_E = 7'b0001000;
  localparam logic [6:0] EN_M = 7'b0000100;
  localparam logic [6:0] EN_W = 7'b0000010;
  localparam logic [6:0] EN_P = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, clear;
  logic        fetch_req, fetch_ack, fetch_err, instr_ok;
  logic [3:0]  icode, icode_q;
  logic        instr_valid, decode_en, execute_en, wb_en, pc_en;
  logic        mem_req, mem_ack, mem_err;
  logic [2:0]  stat;
  logic        busy;
  logic [31:0] cycle_cnt, retired_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cyc = 0;
  int exp_ret = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  y86_seq_controller #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack), .fetch_err(fetch_err),
    .instr_ok(instr_ok), .icode(icode), .icode_q(icode_q),
    .instr_valid(instr_valid), .decode_en(decode_en), .execute_en(execute_en),
    .wb_en(wb_en), .pc_en(pc_en), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_err(mem_err), .stat(stat), .busy(busy),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  // Monitor: one queued expectation per busy cycle.
  always @(negedge clk) begin
    logic [10:0] act, expv;
    if (rst_n && (busy || exp_q.size() != 0)) begin
      act = {busy, fetch_req, decode_en, instr_valid, execute_en, mem_req, wb_en, pc_en, stat};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL trace: unexpected busy cycle, got %b required idle", act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          n_bad++;
          $display("FAIL trace @%0t: got %b required %b", $time, act, expv);
        end
      end
    end
  end

  function automatic bit spec_mem(input logic [3:0] ic);
    return ic inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  function automatic bit spec_wb(input logic [3:0] ic);
    return ic inside {4'd2, 4'd3, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input logic [6:0] en);
    exp_q.push_back({1'b1, en, AOK});
    exp_cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered with the DUT in FETCH; mwait = mem_ack wait cycles before the ack cycle.
  task automatic do_instr(input logic [3:0] ic, input int mwait, input bit stop_e, input bit last);
    fetch_ack = 1'b1; icode = ic; instr_ok = 1'b1; fetch_err = 1'b0;
    expect_cyc(EN_F); tick();
    fetch_ack = 1'b0;
    expect_cyc(EN_D); tick();
    stop = stop_e;
    expect_cyc(EN_E); tick();
    stop = 1'b0;
    if (spec_mem(ic)) begin
      for (int i = 0; i < mwait; i++) begin
        expect_cyc(EN_M); tick();
      end
      mem_ack = 1'b1;
      expect_cyc(EN_M); tick();
      mem_ack = 1'b0;
    end
    if (spec_wb(ic)) begin
      expect_cyc(EN_W); tick();
    end
    stop = last;
    expect_cyc(EN_P); tick();
    exp_ret++;
    stop = 1'b0;
  endtask

  task automatic fetch_fault(input logic [3:0] ic, input bit ok, input bit ferr);
    do_start();
    fetch_ack = 1'b1; icode = ic; instr_ok = ok; fetch_err = ferr;
    expect_cyc(EN_F); tick();
    fetch_ack = 1'b0; instr_ok = 1'b1; fetch_err = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [3:0] mix[8] = '{4'd4, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    fetch_ack = 1'b0; fetch_err = 1'b0; instr_ok = 1'b1; icode = 4'd0;
    mem_ack = 1'b0; mem_err = 1'b0;
    #12;
    check("reset stat", 32'(stat), 32'(AOK));
    check("reset busy", 32'(busy), 0);
    check("reset reqs", 32'({fetch_req, mem_req, decode_en, execute_en, wb_en, pc_en}), 0);
    check("reset icode_q", 32'(icode_q), 0);
    check("reset cycle_cnt", cycle_cnt, 0);
    check("reset retired_cnt", retired_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // nop, nop, halt
    do_start();
    do_instr(4'd1, 0, 1'b0, 1'b0);
    check("retired after first nop", retired_cnt, 1);
    check("cycles after first nop", cycle_cnt, 4);
    do_instr(4'd1, 0, 1'b0, 1'b0);
    fetch_ack = 1'b1; icode = 4'd0;
    expect_cyc(EN_F); tick();
    fetch_ack = 1'b0;
    exp_ret++;
    check("halt stat", 32'(stat), 32'(HLT));
    check("halt busy", 32'(busy), 0);
    check("halt retired", retired_cnt, 3);
    check("halt cycles", cycle_cnt, 32'(exp_cyc));
    start = 1'b1; tick(); tick(); start = 1'b0;
    check("halt ignores start", 32'({busy, stat}), 32'({1'b0, HLT}));
    do_clear();
    check("clear from halt", 32'({busy, stat}), 32'({1'b0, AOK}));

    // mrmovl with 3 memory wait cycles, then stop
    do_start();
    do_instr(4'd5, 3, 1'b0, 1'b1);
    check("mrmovl icode_q", 32'(icode_q), 5);
    check("mrmovl retired", retired_cnt, 32'(exp_ret));
    check("mrmovl cycles", cycle_cnt, 32'(exp_cyc));

    // instruction mix; a stop pulse in EXECUTE of irmovl must be ignored
    do_start();
    foreach (mix[i]) do_instr(mix[i], (i == 0) ? 2 : 0, (mix[i] == 4'd3), (i == 7));
    check("mix idle", 32'({busy, fetch_req}), 0);
    check("mix retired", retired_cnt, 32'(exp_ret));
    check("mix cycles", cycle_cnt, 32'(exp_cyc));

    // fetch faults
    fetch_fault(4'd12, 1'b1, 1'b0);
    check("illegal icode stat", 32'({busy, stat}), 32'({1'b0, INS}));
    check("illegal icode no decode", 32'({decode_en, instr_valid}), 0);
    do_clear();
    fetch_fault(4'd1, 1'b0, 1'b0);
    check("malformed stat", 32'(stat), 32'(INS));
    do_clear();
    fetch_fault(4'd2, 1'b0, 1'b1);
    check("fetch_err priority", 32'(stat), 32'(ADR));
    do_clear();
    check("clear from error", 32'(stat), 32'(AOK));

    // pushq with no mem_ack: 16 memory cycles then ADR fault
    do_start();
    fetch_ack = 1'b1; icode = 4'd10;
    expect_cyc(EN_F); tick();
    fetch_ack = 1'b0;
    expect_cyc(EN_D); tick();
    expect_cyc(EN_E); tick();
    for (int i = 0; i < 16; i++) begin
      expect_cyc(EN_M); tick();
    end
    check("timeout mem_req", 32'(mem_req), 0);
    check("timeout stat", 32'({busy, stat}), 32'({1'b0, ADR}));
    do_clear();

    // pushq acked on the 16th memory cycle proceeds normally
    do_start();
    do_instr(4'd10, 15, 1'b0, 1'b1);
    check("late ack stat", 32'(stat), 32'(AOK));
    check("late ack retired", retired_cnt, 32'(exp_ret));

    // data address fault on ack
    do_start();
    fetch_ack = 1'b1; icode = 4'd8;
    expect_cyc(EN_F); tick();
    fetch_ack = 1'b0;
    expect_cyc(EN_D); tick();
    expect_cyc(EN_E); tick();
    mem_ack = 1'b1; mem_err = 1'b1;
    expect_cyc(EN_M); tick();
    mem_ack = 1'b0; mem_err = 1'b0;
    check("mem_err stat", 32'({busy, stat}), 32'({1'b0, ADR}));
    do_clear();

    // asynchronous reset in MEMORY, then a stale ack
    do_start();
    fetch_ack = 1'b1; icode = 4'd11;
    expect_cyc(EN_F); tick();
    fetch_ack = 1'b0;
    expect_cyc(EN_D); tick();
    expect_cyc(EN_E); tick();
    expect_cyc(EN_M); tick();
    #2;
    rst_n = 1'b0;
    exp_cyc = 0; exp_ret = 0;
    #1;
    check("async reset mem_req", 32'(mem_req), 0);
    check("async reset busy/stat", 32'({busy, stat}), 32'({1'b0, AOK}));
    check("async reset counters", cycle_cnt | retired_cnt, 0);
    check("async reset icode_q", 32'(icode_q), 0);
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    tick(); tick();
    mem_ack = 1'b0;
    check("stale ack stays idle", 32'({busy, fetch_req, mem_req, wb_en, pc_en}), 0);
    check("stale ack cycles", cycle_cnt, 0);

    tick();
    check("scoreboard drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
